// File: rtl/order_manager.sv
// order_manager: generates and retires customer orders and runs the round
// countdown and score. It feeds the graphics stage from registers.
//
// Optional feature macro: ORDER_TIP_EN. When it is defined, a serve earns
// 20 points plus the served order's remaining seconds. Otherwise a serve
// earns a flat 20 points.
//
// Ports:
//   clock        system clock
//   reset        asynchronous, active-high reset
//   game_state   global game state; GAME_STATE_PLAY means "in game"
//   serve        single-cycle pulse: a full bowl was delivered
//   orders       number of active orders, 0..4
//   order_times  remaining seconds per slot; slot 0 is the oldest, invalid slots read 0
//   time_left    round seconds remaining
//   point_total  score, 0..1023
//   serve_ack    one-cycle pulse: the serve matched an order
//   game_over    one-cycle pulse: the round timer reached 0
module order_manager #(
  parameter int unsigned TICKS_PER_SEC   = 65_000_000,
  parameter int unsigned GAME_SECONDS    = 180,
  parameter int unsigned ORDER_LIFE      = 30,
  parameter int unsigned SPAWN_PERIOD    = 10,
  parameter logic [2:0]  GAME_STATE_PLAY = 3'd1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [2:0]      game_state,
  input  logic            serve,
  output logic [3:0]      orders,
  output logic [3:0][4:0] order_times,
  output logic [7:0]      time_left,
  output logic [9:0]      point_total,
  output logic            serve_ack,
  output logic            game_over
);

  localparam int unsigned SEC_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int unsigned SPN_W = $clog2(SPAWN_PERIOD + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PLAY,
    S_DONE
  } state_t;

  state_t           state, state_nx;
  logic             was_play;
  logic [SEC_W-1:0] sec_cnt, sec_cnt_nx;
  logic [SPN_W-1:0] spawn_cnt, spawn_cnt_nx, spawn_inc;

  logic [3:0]       orders_nx;
  logic [3:0][4:0]  times_nx;
  logic [7:0]       time_left_nx;
  logic [9:0]       point_nx;
  logic             ack_nx;
  logic             over_nx;

  logic             play_now;
  logic             tick;
  logic [3:0][4:0]  q;
  logic [3:0]       n;
  logic [3:0][4:0]  q2;
  logic [3:0]       n2;
  logic [2:0]       expired;
  logic [10:0]      reward;
  logic [10:0]      sum;
  logic [10:0]      pen;

  always_comb begin
    state_nx     = state;
    sec_cnt_nx   = sec_cnt;
    spawn_cnt_nx = spawn_cnt;
    spawn_inc    = spawn_cnt + 1'b1;
    orders_nx    = orders;
    times_nx     = order_times;
    time_left_nx = time_left;
    point_nx     = point_total;
    ack_nx       = 1'b0;
    over_nx      = 1'b0;
    play_now     = (game_state == GAME_STATE_PLAY);
    tick         = 1'b0;
    q            = '0;
    n            = '0;
    q2           = '0;
    n2           = '0;
    expired      = '0;
    reward       = '0;
    sum          = '0;
    pen          = '0;

    unique case (state)
      S_IDLE, S_DONE: begin
        // A round starts only on the cycle game_state becomes PLAY, so a
        // finished round stays in DONE until the game state leaves and re-enters PLAY.
        if (play_now && !was_play) begin
          state_nx     = S_PLAY;
          sec_cnt_nx   = '0;
          spawn_cnt_nx = '0;
          orders_nx    = 4'd1;
          times_nx     = '0;
          times_nx[0]  = 5'(ORDER_LIFE);
          time_left_nx = 8'(GAME_SECONDS);
          point_nx     = '0;
        end
      end

      S_PLAY: begin
        if (!play_now) begin
          state_nx = S_IDLE;
        end else begin
          tick       = (sec_cnt == SEC_W'(TICKS_PER_SEC - 1));
          sec_cnt_nx = tick ? '0 : sec_cnt + 1'b1;

          // Serve acts on pre-tick slot 0, so it can never also expire.
          q = order_times;
          n = orders;
          if (serve && (orders != 4'd0)) begin
            ack_nx = 1'b1;
`ifdef ORDER_TIP_EN
            reward = 11'd20 + 11'(order_times[0]);
`else
            reward = 11'd20;
`endif
            q = {5'd0, order_times[3:1]};
            n = orders - 4'd1;
          end

          if (tick) begin
            // Decrement survivors and compact out any that reach zero.
            for (int unsigned i = 0; i < 4; i++) begin
              if (i < 32'(n)) begin
                if (q[i] == 5'd1) begin
                  expired = expired + 3'd1;
                end else begin
                  q2[n2[1:0]] = q[i] - 5'd1;
                  n2          = n2 + 4'd1;
                end
              end
            end

            if (spawn_inc == SPN_W'(SPAWN_PERIOD)) begin
              spawn_cnt_nx = '0;
              if (n2 < 4'd4) begin
                q2[n2[1:0]] = 5'(ORDER_LIFE);
                n2          = n2 + 4'd1;
              end
            end else begin
              spawn_cnt_nx = spawn_inc;
            end

            time_left_nx = time_left - 1'b1;
            if (time_left == 8'd1) begin
              state_nx = S_DONE;
              over_nx  = 1'b1;
            end
          end else begin
            q2 = q;
            n2 = n;
          end

          // Reward saturates first, then the expiry penalty floors at zero.
          sum = 11'(point_total) + reward;
          if (sum > 11'd1023) begin
            sum = 11'd1023;
          end
          pen      = 11'(expired) * 11'd10;
          point_nx = (sum > pen) ? 10'(sum - pen) : '0;

          orders_nx = n2;
          times_nx  = q2;
        end
      end

      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      was_play    <= 1'b0;
      sec_cnt     <= '0;
      spawn_cnt   <= '0;
      orders      <= '0;
      order_times <= '0;
      time_left   <= 8'(GAME_SECONDS);
      point_total <= '0;
      serve_ack   <= 1'b0;
      game_over   <= 1'b0;
    end else begin
      state       <= state_nx;
      was_play    <= play_now;
      sec_cnt     <= sec_cnt_nx;
      spawn_cnt   <= spawn_cnt_nx;
      orders      <= orders_nx;
      order_times <= times_nx;
      time_left   <= time_left_nx;
      point_total <= point_nx;
      serve_ack   <= ack_nx;
      game_over   <= over_nx;
    end
  end

endmodule

// File: tb/tb_order_manager.sv
// Directed testbench for order_manager with TICKS_PER_SEC=4, GAME_SECONDS=20,
// ORDER_LIFE=10, SPAWN_PERIOD=3. The expected score values follow
// ORDER_TIP_EN.
module tb_order_manager;

  logic            clock;
  logic            reset;
  logic [2:0]      game_state;
  logic            serve;
  logic [3:0]      orders;
  logic [3:0][4:0] order_times;
  logic [7:0]      time_left;
  logic [9:0]      point_total;
  logic            serve_ack;
  logic            game_over;

  int checks = 0;
  int passed = 0;

`ifdef ORDER_TIP_EN
  localparam int P_S1 = 27, P_S2 = 57, P_R2 = 23, P_R2_PEN = 13, P_SAME = 34;
`else
  localparam int P_S1 = 20, P_S2 = 40, P_R2 = 20, P_R2_PEN = 10, P_SAME = 30;
`endif

  order_manager #(
    .TICKS_PER_SEC  (4),
    .GAME_SECONDS   (20),
    .ORDER_LIFE     (10),
    .SPAWN_PERIOD   (3),
    .GAME_STATE_PLAY(3'd1)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .game_state (game_state),
    .serve      (serve),
    .orders     (orders),
    .order_times(order_times),
    .time_left  (time_left),
    .point_total(point_total),
    .serve_ack  (serve_ack),
    .game_over  (game_over)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic clk(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; game_state = 3'd0; serve = 1'b0;
    clk(2);
    checks++; if (orders !== 4'd0) $display("FAIL rst_orders: got %0d expected 0", orders); else passed++;
    checks++; if (order_times !== 20'd0) $display("FAIL rst_times: got %h expected 0", order_times); else passed++;
    checks++; if (time_left !== 8'd20) $display("FAIL rst_time_left: got %0d expected 20", time_left); else passed++;
    checks++; if ({serve_ack, game_over, point_total} !== 12'd0) $display("FAIL rst_flags_points: got %h expected 0", {serve_ack, game_over, point_total}); else passed++;
    // Mid-round asynchronous reset.
    reset = 1'b0; game_state = 3'd1;
    clk(6);
    checks++; if (time_left !== 8'd19) $display("FAIL pre_rst_time_left: got %0d expected 19", time_left); else passed++;
    #2 reset = 1'b1;
    #1;
    checks++; if (orders !== 4'd0) $display("FAIL async_rst_orders: got %0d expected 0", orders); else passed++;
    checks++; if (order_times !== 20'd0) $display("FAIL async_rst_times: got %h expected 0", order_times); else passed++;
    checks++; if (time_left !== 8'd20) $display("FAIL async_rst_time_left: got %0d expected 20", time_left); else passed++;
    game_state = 3'd0;
    clk(2);
    reset = 1'b0;
    clk(1);
  endtask

  task automatic test_round_start;
    game_state = 3'd1;
    clk(1);
    checks++; if (orders !== 4'd1) $display("FAIL start_orders: got %0d expected 1", orders); else passed++;
    checks++; if (order_times !== {5'd0, 5'd0, 5'd0, 5'd10}) $display("FAIL start_times: got %h expected %h", order_times, {5'd0, 5'd0, 5'd0, 5'd10}); else passed++;
    checks++; if (point_total !== 10'd0) $display("FAIL start_points: got %0d expected 0", point_total); else passed++;
    clk(3);
    checks++; if (time_left !== 8'd20) $display("FAIL pre_tick_time_left: got %0d expected 20", time_left); else passed++;
    clk(1);
    checks++; if (time_left !== 8'd19) $display("FAIL tick1_time_left: got %0d expected 19", time_left); else passed++;
    checks++; if (order_times[0] !== 5'd9) $display("FAIL tick1_slot0: got %0d expected 9", order_times[0]); else passed++;
    clk(8);
    checks++; if (orders !== 4'd2) $display("FAIL spawn_orders: got %0d expected 2", orders); else passed++;
    checks++; if (order_times !== {5'd0, 5'd0, 5'd10, 5'd7}) $display("FAIL spawn_times: got %h expected %h", order_times, {5'd0, 5'd0, 5'd10, 5'd7}); else passed++;
    checks++; if (time_left !== 8'd17) $display("FAIL spawn_time_left: got %0d expected 17", time_left); else passed++;
  endtask

  task automatic test_serve;
    serve = 1'b1;
    clk(1);
    checks++; if (serve_ack !== 1'b1) $display("FAIL serve_ack: got %b expected 1", serve_ack); else passed++;
    checks++; if (orders !== 4'd1) $display("FAIL serve_orders: got %0d expected 1", orders); else passed++;
    checks++; if (order_times !== {5'd0, 5'd0, 5'd0, 5'd10}) $display("FAIL serve_shift: got %h expected %h", order_times, {5'd0, 5'd0, 5'd0, 5'd10}); else passed++;
    checks++; if (point_total !== 10'(P_S1)) $display("FAIL serve_points: got %0d expected %0d", point_total, P_S1); else passed++;
  endtask

  task automatic test_back_to_back;
    clk(1);
    serve = 1'b0;
    checks++; if (serve_ack !== 1'b1) $display("FAIL b2b_ack: got %b expected 1", serve_ack); else passed++;
    checks++; if (orders !== 4'd0) $display("FAIL b2b_orders: got %0d expected 0", orders); else passed++;
    checks++; if (point_total !== 10'(P_S2)) $display("FAIL b2b_points: got %0d expected %0d", point_total, P_S2); else passed++;
  endtask

  task automatic test_empty_serve;
    serve = 1'b1;
    clk(1);
    serve = 1'b0;
    checks++; if (serve_ack !== 1'b0) $display("FAIL empty_ack: got %b expected 0", serve_ack); else passed++;
    checks++; if (orders !== 4'd0) $display("FAIL empty_orders: got %0d expected 0", orders); else passed++;
    checks++; if (point_total !== 10'(P_S2)) $display("FAIL empty_points: got %0d expected %0d", point_total, P_S2); else passed++;
  endtask

  task automatic test_expiry;
    game_state = 3'd0;
    clk(1);
    game_state = 3'd1;
    clk(1);
    clk(39);
    checks++; if (orders !== 4'd4) $display("FAIL full_orders: got %0d expected 4", orders); else passed++;
    checks++; if (order_times !== {5'd10, 5'd7, 5'd4, 5'd1}) $display("FAIL full_times: got %h expected %h", order_times, {5'd10, 5'd7, 5'd4, 5'd1}); else passed++;
    clk(1);
    checks++; if (orders !== 4'd3) $display("FAIL expire0_orders: got %0d expected 3", orders); else passed++;
    checks++; if (order_times !== {5'd0, 5'd9, 5'd6, 5'd3}) $display("FAIL expire0_times: got %h expected %h", order_times, {5'd0, 5'd9, 5'd6, 5'd3}); else passed++;
    checks++; if (point_total !== 10'd0) $display("FAIL expire0_floor: got %0d expected 0", point_total); else passed++;
    checks++; if (time_left !== 8'd10) $display("FAIL expire0_time_left: got %0d expected 10", time_left); else passed++;
    serve = 1'b1;
    clk(1);
    serve = 1'b0;
    checks++; if (point_total !== 10'(P_R2)) $display("FAIL r2_serve_points: got %0d expected %0d", point_total, P_R2); else passed++;
    clk(23);
    checks++; if (orders !== 4'd3) $display("FAIL expire1_orders: got %0d expected 3", orders); else passed++;
    checks++; if (order_times !== {5'd0, 5'd9, 5'd6, 5'd3}) $display("FAIL expire1_times: got %h expected %h", order_times, {5'd0, 5'd9, 5'd6, 5'd3}); else passed++;
    checks++; if (point_total !== 10'(P_R2_PEN)) $display("FAIL expire1_penalty: got %0d expected %0d", point_total, P_R2_PEN); else passed++;
  endtask

  task automatic test_serve_on_expiry;
    clk(11);
    serve = 1'b1;
    clk(1);
    serve = 1'b0;
    checks++; if (serve_ack !== 1'b1) $display("FAIL same_ack: got %b expected 1", serve_ack); else passed++;
    checks++; if (orders !== 4'd3) $display("FAIL same_orders: got %0d expected 3", orders); else passed++;
    checks++; if (order_times !== {5'd0, 5'd9, 5'd6, 5'd3}) $display("FAIL same_times: got %h expected %h", order_times, {5'd0, 5'd9, 5'd6, 5'd3}); else passed++;
    checks++; if (point_total !== 10'(P_SAME)) $display("FAIL same_points: got %0d expected %0d", point_total, P_SAME); else passed++;
    checks++; if (time_left !== 8'd1) $display("FAIL same_time_left: got %0d expected 1", time_left); else passed++;
  endtask

  task automatic test_round_end;
    clk(3);
    checks++; if (game_over !== 1'b0) $display("FAIL over_early: got %b expected 0", game_over); else passed++;
    clk(1);
    checks++; if (game_over !== 1'b1) $display("FAIL over_pulse: got %b expected 1", game_over); else passed++;
    checks++; if (time_left !== 8'd0) $display("FAIL over_time_left: got %0d expected 0", time_left); else passed++;
    checks++; if (order_times !== {5'd0, 5'd8, 5'd5, 5'd2}) $display("FAIL over_times: got %h expected %h", order_times, {5'd0, 5'd8, 5'd5, 5'd2}); else passed++;
    clk(1);
    checks++; if (game_over !== 1'b0) $display("FAIL over_width: got %b expected 0", game_over); else passed++;
    clk(10);
    checks++; if (time_left !== 8'd0) $display("FAIL done_time_left: got %0d expected 0", time_left); else passed++;
    checks++; if (orders !== 4'd3) $display("FAIL done_no_spawn: got %0d expected 3", orders); else passed++;
    checks++; if (order_times !== {5'd0, 5'd8, 5'd5, 5'd2}) $display("FAIL done_frozen: got %h expected %h", order_times, {5'd0, 5'd8, 5'd5, 5'd2}); else passed++;
    serve = 1'b1;
    clk(1);
    serve = 1'b0;
    checks++; if (serve_ack !== 1'b0) $display("FAIL done_serve_ack: got %b expected 0", serve_ack); else passed++;
    checks++; if ({orders, point_total} !== {4'd3, 10'(P_SAME)}) $display("FAIL done_serve_state: got %h expected %h", {orders, point_total}, {4'd3, 10'(P_SAME)}); else passed++;
    game_state = 3'd0;
    clk(1);
    game_state = 3'd1;
    clk(1);
    checks++; if (time_left !== 8'd20) $display("FAIL restart_time_left: got %0d expected 20", time_left); else passed++;
    checks++; if (point_total !== 10'd0) $display("FAIL restart_points: got %0d expected 0", point_total); else passed++;
    checks++; if (order_times !== {5'd0, 5'd0, 5'd0, 5'd10}) $display("FAIL restart_times: got %h expected %h", order_times, {5'd0, 5'd0, 5'd0, 5'd10}); else passed++;
  endtask

  task automatic test_idle_serve;
    game_state = 3'd0;
    clk(6);
    checks++; if (time_left !== 8'd20) $display("FAIL idle_hold_time_left: got %0d expected 20", time_left); else passed++;
    serve = 1'b1;
    clk(1);
    serve = 1'b0;
    checks++; if (serve_ack !== 1'b0) $display("FAIL idle_serve_ack: got %b expected 0", serve_ack); else passed++;
    checks++; if ({orders, order_times, point_total} !== {4'd1, 5'd0, 5'd0, 5'd0, 5'd10, 10'd0}) $display("FAIL idle_serve_state: got %h expected %h", {orders, order_times, point_total}, {4'd1, 5'd0, 5'd0, 5'd0, 5'd10, 10'd0}); else passed++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_round_start;
    test_serve;
    test_back_to_back;
    test_empty_serve;
    test_expiry;
    test_serve_on_expiry;
    test_round_end;
    test_idle_serve;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
